hdmi_frame_sequencer: RTL and testbench
=======================================

# hdmi_frame_sequencer

Video timing and period sequencer for the HDMI/DVI transmit path, one per link, driving all three `tmds_channel` instances.
- Scans a raster, requests pixels from the frame source, and issues per-pixel `mode`, `video_data` and per-channel `control_data`.
- Covers control periods with sync, video preamble, video guard band and active video.
- Data islands are out of scope: `mode` 3/4 are never issued and `data_island_data` is tied 0 at the top level.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch; must be ≥ 10 when DVI_OUTPUT = 0
- V_ACTIVE, 480, active lines
- V_FRONT, 10, vertical front porch lines
- V_SYNC, 2, vsync lines
- V_BACK, 33, vertical back porch lines
- HSYNC_POL, 0, hsync asserted level
- VSYNC_POL, 0, vsync asserted level
- DVI_OUTPUT, 0, 1 = plain DVI (no preamble, no guard band)

Ports:
- clk_pixel  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- cx  out  10  current horizontal counter, 0..H_TOTAL-1
- cy  out  10  current vertical counter, 0..V_TOTAL-1
- pix_req  out  1  (cx,cy) is an active pixel; rgb must be valid this cycle
- rgb  in  24  {R,G,B} for (cx,cy), combinational from the frame source
- frame_start  out  1  one-cycle pulse, outputs show (0,0)
- mode  out  3  to all channels: 0 control, 1 video, 2 video guard
- video_data0/1/2  out  8  B, G, R to channels 0/1/2
- control_data0  out  2  {vsync,hsync} to channel 0
- control_data1/2  out  2  {CTL1,CTL0} / {CTL3,CTL2} to channels 1/2

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Active region is cx < H_ACTIVE and cy < V_ACTIVE. Line order is active, front porch, sync, back porch.
- Counter behaviour:
  - cx increments every cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, cy increments and wraps from V_TOTAL-1 to 0.
  - Both are registers; pix_req = (cx,cy) active, decoded combinationally.
- Sync:
  - hsync is asserted (= HSYNC_POL) for H_ACTIVE+H_FRONT ≤ cx < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync is asserted (= VSYNC_POL) for V_ACTIVE+V_FRONT ≤ cy < V_ACTIVE+V_FRONT+V_SYNC, for the entire line.
- next_active = ((cy+1) mod V_TOTAL) < V_ACTIVE.
- Period decode per (cx,cy), priority top-down:
  - VIDEO (mode 1): pix_req.
  - GUARD (mode 2): DVI_OUTPUT = 0, next_active, cx ∈ {H_TOTAL-2, H_TOTAL-1}.
  - PREAMBLE (mode 0): DVI_OUTPUT = 0, next_active, H_TOTAL-10 ≤ cx ≤ H_TOTAL-3.
  - CONTROL (mode 0): otherwise.
- Control data by period:
  - PREAMBLE: control_data1 = 2'b01, control_data2 = 2'b00 (video preamble CTL0..3 = 1,0,0,0).
  - All other periods: control_data1 = control_data2 = 2'b00.
  - control_data0 = {vsync,hsync} in every period.
- video_data0/1/2 = rgb[7:0], rgb[15:8], rgb[23:16] in VIDEO; 8'h00 otherwise.
- frame_start is asserted for the output cycle of (0,0).

## Timing
- Counter-to-output latency is 1 cycle. Outputs registered on the rising edge of clk_pixel reflect the (cx,cy) and rgb of the previous cycle.
- rgb is sampled in exactly the cycle pix_req is high. There is no backpressure; the frame source must meet it.
- With tmds_channel's registered output, the TMDS word for pixel (cx,cy) appears 2 cycles after pix_req.
- Reset (rst_n low, async) sets:
  - cx = 0, cy = 0
  - mode = 0, video_data* = 0, frame_start = 0
  - control_data0 = {~VSYNC_POL,~HSYNC_POL}
  - control_data1 = control_data2 = 0
- On release, the first edge outputs (0,0) with frame_start = 1.
- Reset mid-line or mid-frame restarts at (0,0); the partial frame is discarded with no extra pulse.
- Preamble/guard on the last line (cy = V_TOTAL-1) precedes line 0 of the next frame.
- No preamble/guard on line V_ACTIVE-1, which is followed by front-porch line V_ACTIVE.
- The guard is never split by the cx wrap; the 2 guard cycles immediately precede pixel cx = 0.

## Test plan
- Reset release with defaults: first output cycle mode = 0, frame_start = 1, control_data0 = 2'b11 (inactive, negative polarity). frame_start then recurs every 800×525 = 420000 cycles.
- Line 0, defaults: 8 preamble cycles for cx 790..797 of line 524 (control_data1 = 01), guard for cx 798..799 (mode = 2), then 640 cycles of mode = 1.
  - video_data0 = rgb[7:0] with a counter-pattern rgb = {cy,cx}.
  - Each word lags pix_req by 1 cycle.
- Sync: hsync low (control_data0[0] = 0) for cx 656..751, output at cx+1. vsync low on lines 490..491 only; no preamble/guard on lines 479..523.
- DVI_OUTPUT = 1: mode ∈ {0,1} only, control_data1/2 always 00; active-pixel timing identical to the default case.
- Assert rst_n low at cx = 300, cy = 200 for 3 cycles: outputs take reset values immediately (asynchronously). After release, the first output is (0,0) with frame_start = 1.
- Small raster (H 8/2/2/10, V 4/1/1/2, DVI_OUTPUT = 0): H_TOTAL = 22, V_TOTAL = 8.
  - Check the full-frame mode sequence against the golden model, including the guard at cx 20..21 of line 7 (wrap into the next frame).

Source files
------------

// File: rtl/hdmi_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_frame_sequencer
// Purpose  : Video timing and period sequencer for one HDMI/DVI transmit link.
//            It scans the raster, requests pixels from the frame source, and
//            issues per-pixel mode, video data and per-channel control data
//            to the three TMDS channel encoders. Data islands are not
//            generated (mode 3/4 never issued).
// Ports    : clk_pixel      - pixel clock
//            rst_n          - asynchronous active-low reset
//            cx, cy         - current raster counters (registers)
//            pix_req        - (cx,cy) is an active pixel, rgb must be valid
//            rgb            - {R,G,B} for (cx,cy), combinational from source
//            frame_start    - registered pulse for the output cycle of (0,0)
//            mode           - 0 control, 1 video, 2 video guard band
//            video_data0..2 - B, G, R to channels 0..2
//            control_data0  - {vsync,hsync}
//            control_data1/2- {CTL1,CTL0} / {CTL3,CTL2}
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_frame_sequencer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter bit DVI_OUTPUT = 1'b0
) (
  input  logic        clk_pixel,
  input  logic        rst_n,
  output logic [9:0]  cx,
  output logic [9:0]  cy,
  output logic        pix_req,
  input  logic [23:0] rgb,
  output logic        frame_start,
  output logic [2:0]  mode,
  output logic [7:0]  video_data0,
  output logic [7:0]  video_data1,
  output logic [7:0]  video_data2,
  output logic [1:0]  control_data0,
  output logic [1:0]  control_data1,
  output logic [1:0]  control_data2
);

  localparam logic [9:0] c_h_active    = 10'(H_ACTIVE);
  localparam logic [9:0] c_h_last      = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] c_hs_start    = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] c_hs_end      = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  // Guard occupies the last two cycles of the line, preamble the eight before.
  localparam logic [9:0] c_guard_start = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 2);
  localparam logic [9:0] c_pre_start   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 10);
  localparam logic [9:0] c_v_active    = 10'(V_ACTIVE);
  localparam logic [9:0] c_v_last      = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] c_vs_start    = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] c_vs_end      = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [2:0] c_mode_control = 3'd0;
  localparam logic [2:0] c_mode_video   = 3'd1;
  localparam logic [2:0] c_mode_guard   = 3'd2;

  logic [9:0] cx_q, cx_d;
  logic [9:0] cy_q, cy_d;
  logic       frame_start_q, frame_start_d;
  logic [2:0] mode_q, mode_d;
  logic [7:0] vd0_q, vd0_d, vd1_q, vd1_d, vd2_q, vd2_d;
  logic [1:0] cd0_q, cd0_d, cd1_q, cd1_d, cd2_q, cd2_d;

  logic       h_last, v_last, active, next_active, in_guard, in_pre;
  logic       hsync, vsync;
  logic [9:0] cy_next_line;

  always_comb begin
    h_last       = (cx_q == c_h_last);
    v_last       = (cy_q == c_v_last);
    cy_next_line = v_last ? 10'd0 : cy_q + 10'd1;

    cx_d = h_last ? 10'd0 : cx_q + 10'd1;
    cy_d = h_last ? cy_next_line : cy_q;

    active      = (cx_q < c_h_active) && (cy_q < c_v_active);
    // Preamble/guard announce the line that follows, so they key off the
    // next line being active (including the wrap from the last line).
    next_active = (cy_next_line < c_v_active);
    in_guard    = !DVI_OUTPUT && next_active && (cx_q >= c_guard_start);
    in_pre      = !DVI_OUTPUT && next_active && (cx_q >= c_pre_start)
                  && (cx_q < c_guard_start);

    hsync = ((cx_q >= c_hs_start) && (cx_q < c_hs_end)) ? HSYNC_POL : ~HSYNC_POL;
    vsync = ((cy_q >= c_vs_start) && (cy_q < c_vs_end)) ? VSYNC_POL : ~VSYNC_POL;

    frame_start_d = (cx_q == 10'd0) && (cy_q == 10'd0);
    mode_d        = c_mode_control;
    vd0_d         = 8'h00;
    vd1_d         = 8'h00;
    vd2_d         = 8'h00;
    cd0_d         = {vsync, hsync};
    cd1_d         = 2'b00;
    cd2_d         = 2'b00;

    if (active) begin
      mode_d = c_mode_video;
      vd0_d  = rgb[7:0];
      vd1_d  = rgb[15:8];
      vd2_d  = rgb[23:16];
    end else if (in_guard) begin
      mode_d = c_mode_guard;
    end else if (in_pre) begin
      cd1_d = 2'b01;  // video preamble CTL0..3 = 1,0,0,0
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      cx_q          <= 10'd0;
      cy_q          <= 10'd0;
      frame_start_q <= 1'b0;
      mode_q        <= c_mode_control;
      vd0_q         <= 8'h00;
      vd1_q         <= 8'h00;
      vd2_q         <= 8'h00;
      cd0_q         <= {~VSYNC_POL, ~HSYNC_POL};
      cd1_q         <= 2'b00;
      cd2_q         <= 2'b00;
    end else begin
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      vd0_q         <= vd0_d;
      vd1_q         <= vd1_d;
      vd2_q         <= vd2_d;
      cd0_q         <= cd0_d;
      cd1_q         <= cd1_d;
      cd2_q         <= cd2_d;
    end
  end

  assign cx            = cx_q;
  assign cy            = cy_q;
  assign pix_req       = active;
  assign frame_start   = frame_start_q;
  assign mode          = mode_q;
  assign video_data0   = vd0_q;
  assign video_data1   = vd1_q;
  assign video_data2   = vd2_q;
  assign control_data0 = cd0_q;
  assign control_data1 = cd1_q;
  assign control_data2 = cd2_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_frame_sequencer
// Purpose  : Self-checking bench for hdmi_frame_sequencer. Three instances
//            run side by side: [0] small raster H 8/2/2/10 V 4/1/1/2,
//            [1] same raster as plain DVI with positive sync polarity,
//            [2] default 640x480 timing. A golden raster model pushes the
//            expected registered outputs for every scanned (cx,cy); they are
//            popped one cycle later when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_frame_sequencer;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp, dvi;
  } cfg_t;

  typedef struct packed {
    logic       fs;
    logic [2:0] mode;
    logic [7:0] v0, v1, v2;
    logic [1:0] c0, c1, c2;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstn;
  logic [9:0]  ocx [3];
  logic [9:0]  ocy [3];
  logic        preq [3];
  logic [23:0] rgbw [3];
  outs_t       obs [3];

  logic        fs   [3];
  logic [2:0]  md   [3];
  logic [7:0]  vd0 [3], vd1 [3], vd2 [3];
  logic [1:0]  cd0 [3], cd1 [3], cd2 [3];

  cfg_t  cfg [3];
  int    mx [3];
  int    my [3];
  outs_t sb [3][$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  // Counter-pattern frame source: rgb = {4'hA, cy, cx}.
  function automatic logic [23:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {4'hA, y, x};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_wire
    assign rgbw[g] = pat(ocx[g], ocy[g]);
    assign obs[g]  = {fs[g], md[g], vd0[g], vd1[g], vd2[g], cd0[g], cd1[g], cd2[g]};
  end

  hdmi_frame_sequencer #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(10),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .DVI_OUTPUT(1'b0)
  ) u_small (
    .clk_pixel(clk), .rst_n(rstn[0]), .cx(ocx[0]), .cy(ocy[0]), .pix_req(preq[0]),
    .rgb(rgbw[0]), .frame_start(fs[0]), .mode(md[0]),
    .video_data0(vd0[0]), .video_data1(vd1[0]), .video_data2(vd2[0]),
    .control_data0(cd0[0]), .control_data1(cd1[0]), .control_data2(cd2[0])
  );

  hdmi_frame_sequencer #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(10),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DVI_OUTPUT(1'b1)
  ) u_dvi (
    .clk_pixel(clk), .rst_n(rstn[1]), .cx(ocx[1]), .cy(ocy[1]), .pix_req(preq[1]),
    .rgb(rgbw[1]), .frame_start(fs[1]), .mode(md[1]),
    .video_data0(vd0[1]), .video_data1(vd1[1]), .video_data2(vd2[1]),
    .control_data0(cd0[1]), .control_data1(cd1[1]), .control_data2(cd2[1])
  );

  hdmi_frame_sequencer u_def (
    .clk_pixel(clk), .rst_n(rstn[2]), .cx(ocx[2]), .cy(ocy[2]), .pix_req(preq[2]),
    .rgb(rgbw[2]), .frame_start(fs[2]), .mode(md[2]),
    .video_data0(vd0[2]), .video_data1(vd1[2]), .video_data2(vd2[2]),
    .control_data0(cd0[2]), .control_data1(cd1[2]), .control_data2(cd2[2])
  );

  // Golden model of the registered outputs produced for raster position (x,y).
  function automatic outs_t model(input cfg_t c, input int x, input int y,
                                  input logic [23:0] px);
    outs_t o;
    int    ht, vt;
    bit    act, nact, hsy, vsy;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    act  = (x < c.ha) && (y < c.va);
    nact = (((y + 1) % vt) < c.va);
    hsy  = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
    vsy  = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? c.vp : !c.vp;
    o      = '0;
    o.fs   = (x == 0) && (y == 0);
    o.c0   = {vsy, hsy};
    if (act) begin
      o.mode = 3'd1;
      o.v0   = px[7:0];
      o.v1   = px[15:8];
      o.v2   = px[23:16];
    end else if (!c.dvi && nact && x >= ht - 2) begin
      o.mode = 3'd2;
    end else if (!c.dvi && nact && x >= ht - 10 && x <= ht - 3) begin
      o.c1 = 2'b01;
    end
    return o;
  endfunction

  task automatic check_reset(input int i);
    outs_t r;
    r    = '0;
    r.c0 = {~cfg[i].vp, ~cfg[i].hp};
    n_cmp++;
    assert (obs[i] === r) else begin
      n_fail++;
      $error("FAIL reset_out[%0d] observed=%h expected=%h", i, obs[i], r);
    end
    n_cmp++;
    assert ({ocx[i], ocy[i]} === 20'd0) else begin
      n_fail++;
      $error("FAIL reset_cnt[%0d] observed=(%0d,%0d) expected=(0,0)", i, ocx[i], ocy[i]);
    end
  endtask

  // One clock: push expectations for the current position, let the edge pass,
  // then at the falling edge pop and compare what the DUT registered.
  task automatic tick();
    outs_t e;
    bit    pr;
    for (int i = 0; i < 3; i++) begin
      if (rstn[i]) begin
        sb[i].push_back(model(cfg[i], mx[i], my[i], pat(10'(mx[i]), 10'(my[i]))));
        mx[i]++;
        if (mx[i] == cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb) begin
          mx[i] = 0;
          my[i]++;
          if (my[i] == cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb) my[i] = 0;
        end
      end else begin
        mx[i] = 0;
        my[i] = 0;
        sb[i].delete();
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        check_reset(i);
      end else begin
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          n_cmp++;
          assert (obs[i] === e) else begin
            n_fail++;
            $error("FAIL out[%0d] at cnt=(%0d,%0d) observed=%h expected=%h",
                   i, mx[i], my[i], obs[i], e);
          end
        end
        pr = (mx[i] < cfg[i].ha) && (my[i] < cfg[i].va);
        n_cmp++;
        assert ({ocx[i], ocy[i], preq[i]} === {10'(mx[i]), 10'(my[i]), pr}) else begin
          n_fail++;
          $error("FAIL cnt[%0d] observed=(%0d,%0d,req=%0b) expected=(%0d,%0d,req=%0b)",
                 i, ocx[i], ocy[i], preq[i], mx[i], my[i], pr);
        end
      end
    end
  endtask

  initial begin
    cfg[0] = '{8, 2, 2, 10, 4, 1, 1, 2, 1'b0, 1'b0, 1'b0};
    cfg[1] = '{8, 2, 2, 10, 4, 1, 1, 2, 1'b1, 1'b1, 1'b1};
    cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
    rstn = 3'b000;

    // Reset held: all outputs at reset values.
    repeat (3) tick();
    rstn = 3'b111;

    // Two full default lines (guard at 798..799 before line 1, hsync
    // 656..751) while the small rasters wrap through several frames.
    repeat (1650) tick();

    // Mid-frame asynchronous reset of the small raster at (5,3), and of the
    // default raster wherever it happens to be.
    begin
      int k;
      k = 0;
      while (k < 400 && !(mx[0] == 5 && my[0] == 3)) begin
        tick();
        k++;
      end
      n_cmp++;
      assert (mx[0] == 5 && my[0] == 3) else begin
        n_fail++;
        $error("FAIL seek_midframe observed=(%0d,%0d) expected=(5,3)", mx[0], my[0]);
      end
    end
    rstn[0] = 1'b0;
    rstn[2] = 1'b0;
    #1;
    check_reset(0);
    check_reset(2);
    repeat (3) tick();
    rstn = 3'b111;

    // Restart from (0,0) with frame_start, then more frames.
    repeat (400) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
